commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit.sv | 180 ++++++++++++++++++
 tb/tb_commit_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head and writes the register file.
// Performs stores through a blocking handshake and flushes the pipeline on a branch mispredict.
module commit_unit #(
    parameter int unsigned ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    // ROB head
    input  logic                commit_valid,
    input  logic [ROB_ID_W-1:0] commit_id,
    input  logic [7:0]          commit_op,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_value,
    input  logic [31:0]         commit_pc,
    input  logic [31:0]         commit_addr,
    input  logic                commit_pred,
    input  logic                commit_outcome,
    input  logic [31:0]         commit_pred_target,
    output logic                commit_ack,
    // register file
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [ROB_ID_W-1:0] rf_rob_id,
    // store port
    output logic                mem_wr_req,
    output logic [31:0]         mem_wr_addr,
    output logic [31:0]         mem_wr_data,
    output logic [1:0]          mem_wr_size,
    input  logic                mem_wr_done,
    // flush
    output logic                flush_o,
    output logic [31:0]         redirect_pc,
    // statistics
    output logic [31:0]         cnt_retired,
    output logic [31:0]         cnt_flush
);

    // Opcodes that select a non-default commit path; every other code retires directly.
    localparam logic [7:0] AluOpSb   = 8'h20;
    localparam logic [7:0] AluOpSh   = 8'h21;
    localparam logic [7:0] AluOpSw   = 8'h22;
    localparam logic [7:0] AluOpBeq  = 8'h28;
    localparam logic [7:0] AluOpBne  = 8'h29;
    localparam logic [7:0] AluOpBlt  = 8'h2A;
    localparam logic [7:0] AluOpBge  = 8'h2B;
    localparam logic [7:0] AluOpBltu = 8'h2C;
    localparam logic [7:0] AluOpBgeu = 8'h2D;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StStoreWait = 2'd1,
        StFlush     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] st_addr_q, st_addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic [1:0]  st_size_q, st_size_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] retired_q, flush_cnt_q;

    logic        is_br;
    logic        is_st;
    logic [1:0]  op_size;
    logic        mispredict;

    always_comb begin
        is_br   = 1'b0;
        is_st   = 1'b0;
        op_size = 2'd2;
        case (commit_op)
            AluOpBeq, AluOpBne, AluOpBlt,
            AluOpBge, AluOpBltu, AluOpBgeu: is_br = 1'b1;
            AluOpSb: begin
                is_st   = 1'b1;
                op_size = 2'd0;
            end
            AluOpSh: begin
                is_st   = 1'b1;
                op_size = 2'd1;
            end
            AluOpSw: begin
                is_st   = 1'b1;
                op_size = 2'd2;
            end
            default: ;
        endcase
    end

    assign mispredict = (commit_pred != commit_outcome) ||
                        (commit_outcome && (commit_pred_target != commit_addr));

    always_comb begin
        state_d    = state_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        st_size_d  = st_size_q;
        redirect_d = redirect_q;
        commit_ack = 1'b0;
        rf_we      = 1'b0;
        mem_wr_req = 1'b0;
        flush_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (commit_valid) begin
                    if (is_st) begin
                        st_addr_d = commit_addr;
                        st_data_d = commit_value;
                        st_size_d = op_size;
                        state_d   = StStoreWait;
                    end else if (is_br && mispredict) begin
                        redirect_d = commit_outcome ? commit_addr : commit_pc + 32'd4;
                        state_d    = StFlush;
                    end else begin
                        commit_ack = 1'b1;
                        rf_we      = !is_br && (commit_rd != 5'd0);
                    end
                end
            end
            StStoreWait: begin
                mem_wr_req = 1'b1;
                if (mem_wr_done) begin
                    // The store is performed either way; the ack still needs a valid head.
                    commit_ack = commit_valid;
                    state_d    = StIdle;
                end
            end
            StFlush: begin
                flush_o = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The reset cycle must present a quiet interface.
        if (!rst) begin
            commit_ack = 1'b0;
            rf_we      = 1'b0;
            mem_wr_req = 1'b0;
            flush_o    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            st_addr_q   <= 32'd0;
            st_data_q   <= 32'd0;
            st_size_q   <= 2'd0;
            redirect_q  <= 32'd0;
            retired_q   <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            st_size_q  <= st_size_d;
            redirect_q <= redirect_d;
            if (commit_ack) begin
                retired_q <= retired_q + 32'd1;
            end
            if (flush_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign rf_waddr    = commit_rd;
    assign rf_wdata    = commit_value;
    assign rf_rob_id   = commit_id;
    assign mem_wr_addr = st_addr_q;
    assign mem_wr_data = st_data_q;
    assign mem_wr_size = st_size_q;
    assign redirect_pc = redirect_q;
    assign cnt_retired = retired_q;
    assign cnt_flush   = flush_cnt_q;

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit.
// The expected values used here were worked out by hand from the commit rules.
module tb_commit_unit;

    localparam int unsigned RobIdW = 4;

    localparam logic [7:0] OpAdd  = 8'h01;
    localparam logic [7:0] OpAddi = 8'h0B;
    localparam logic [7:0] OpSb   = 8'h20;
    localparam logic [7:0] OpSh   = 8'h21;
    localparam logic [7:0] OpSw   = 8'h22;
    localparam logic [7:0] OpBeq  = 8'h28;
    localparam logic [7:0] OpBne  = 8'h29;
    localparam logic [7:0] OpBlt  = 8'h2A;

    logic              clk = 1'b0;
    logic              rst;
    logic              commit_valid;
    logic [RobIdW-1:0] commit_id;
    logic [7:0]        commit_op;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_value, commit_pc, commit_addr, commit_pred_target;
    logic              commit_pred, commit_outcome;
    logic              commit_ack, rf_we, mem_wr_req, mem_wr_done, flush_o;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata, mem_wr_addr, mem_wr_data, redirect_pc;
    logic [RobIdW-1:0] rf_rob_id;
    logic [1:0]        mem_wr_size;
    logic [31:0]       cnt_retired, cnt_flush;

    int n_tests = 0;
    int n_fail  = 0;

    commit_unit #(.ROB_ID_W(RobIdW)) dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid       (commit_valid),
        .commit_id          (commit_id),
        .commit_op          (commit_op),
        .commit_rd          (commit_rd),
        .commit_value       (commit_value),
        .commit_pc          (commit_pc),
        .commit_addr        (commit_addr),
        .commit_pred        (commit_pred),
        .commit_outcome     (commit_outcome),
        .commit_pred_target (commit_pred_target),
        .commit_ack         (commit_ack),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .rf_rob_id          (rf_rob_id),
        .mem_wr_req         (mem_wr_req),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_size        (mem_wr_size),
        .mem_wr_done        (mem_wr_done),
        .flush_o            (flush_o),
        .redirect_pc        (redirect_pc),
        .cnt_retired        (cnt_retired),
        .cnt_flush          (cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic [7:0] op, input logic [4:0] rd, input logic [31:0] value,
                        input logic [31:0] pc, input logic [31:0] addr, input logic pred,
                        input logic outcome, input logic [31:0] ptgt);
        commit_valid       = 1'b1;
        commit_op          = op;
        commit_rd          = rd;
        commit_value       = value;
        commit_pc          = pc;
        commit_addr        = addr;
        commit_pred        = pred;
        commit_outcome     = outcome;
        commit_pred_target = ptgt;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        commit_valid = 1'b0; commit_id = 4'd3; commit_op = OpAdd; commit_rd = 5'd0;
        commit_value = '0; commit_pc = '0; commit_addr = '0; commit_pred = 1'b0;
        commit_outcome = 1'b0; commit_pred_target = '0; mem_wr_done = 1'b0;
        step();
        // Reset cycle with a retirable head presented: interface must stay quiet.
        head(OpAdd, 5'd7, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rst_ack", {31'd0, commit_ack}, 32'd0);
        check("rst_rfwe", {31'd0, rf_we}, 32'd0);
        step();
        commit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_cnt_ret", cnt_retired, 32'd0);
        check("rst_cnt_fl", cnt_flush, 32'd0);
        check("rst_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_redir", redirect_pc, 32'd0);
        check("idle_noval_ack", {31'd0, commit_ack}, 32'd0);

        // ADD rd=5 retires in the same cycle.
        head(OpAdd, 5'd5, 32'h1234, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        check("add_ack", {31'd0, commit_ack}, 32'd1);
        check("add_we", {31'd0, rf_we}, 32'd1);
        check("add_waddr", {27'd0, rf_waddr}, 32'd5);
        check("add_wdata", rf_wdata, 32'h1234);
        check("add_robid", {28'd0, rf_rob_id}, 32'd3);
        step();
        commit_valid = 1'b0;
        #1;
        check("add_cnt", cnt_retired, 32'd1);

        // ADDI rd=0: retires without a register write.
        head(OpAddi, 5'd0, 32'h99, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0);
        check("addi_ack", {31'd0, commit_ack}, 32'd1);
        check("addi_we", {31'd0, rf_we}, 32'd0);
        step();
        commit_valid = 1'b0;
        mem_wr_done  = 1'b1;
        #1;
        check("spur_ack", {31'd0, commit_ack}, 32'd0);
        step();
        mem_wr_done = 1'b0;
        #1;
        check("spur_req", {31'd0, mem_wr_req}, 32'd0);
        check("spur_cnt", cnt_retired, 32'd2);

        // SW with completion on the third wait cycle.
        head(OpSw, 5'd0, 32'hDEADBEEF, 32'h108, 32'h1000, 1'b0, 1'b0, 32'h0);
        check("sw_ack0", {31'd0, commit_ack}, 32'd0);
        check("sw_req0", {31'd0, mem_wr_req}, 32'd0);
        step();
        // Disturb the head fields: the store port must hold the latched copy.
        commit_addr  = 32'hFFFF0000;
        commit_value = 32'h0;
        for (int i = 0; i < 3; i++) begin
            mem_wr_done = (i == 2);
            #1;
            check("sw_req", {31'd0, mem_wr_req}, 32'd1);
            check("sw_addr", mem_wr_addr, 32'h1000);
            check("sw_data", mem_wr_data, 32'hDEADBEEF);
            check("sw_size", {30'd0, mem_wr_size}, 32'd2);
            check("sw_ack", {31'd0, commit_ack}, (i == 2) ? 32'd1 : 32'd0);
            step();
        end
        mem_wr_done  = 1'b0;
        commit_valid = 1'b0;
        #1;
        check("sw_req_end", {31'd0, mem_wr_req}, 32'd0);
        check("sw_cnt", cnt_retired, 32'd3);

        // SB and SH at minimum latency: size encoding.
        head(OpSb, 5'd0, 32'h11, 32'h10C, 32'h2001, 1'b0, 1'b0, 32'h0);
        step();
        mem_wr_done = 1'b1;
        #1;
        check("sb_size", {30'd0, mem_wr_size}, 32'd0);
        check("sb_ack", {31'd0, commit_ack}, 32'd1);
        step();
        mem_wr_done = 1'b0;
        head(OpSh, 5'd0, 32'h2222, 32'h110, 32'h2002, 1'b0, 1'b0, 32'h0);
        step();
        mem_wr_done = 1'b1;
        #1;
        check("sh_size", {30'd0, mem_wr_size}, 32'd1);
        check("sh_addr", mem_wr_addr, 32'h2002);
        step();
        mem_wr_done  = 1'b0;
        commit_valid = 1'b0;
        #1;
        check("st_cnt", cnt_retired, 32'd5);

        // BEQ mispredicted not-taken: flush to the resolved target.
        head(OpBeq, 5'd9, 32'h0, 32'h114, 32'h200, 1'b0, 1'b1, 32'h0);
        check("beq_ack0", {31'd0, commit_ack}, 32'd0);
        check("beq_fl0", {31'd0, flush_o}, 32'd0);
        step();
        check("beq_flush", {31'd0, flush_o}, 32'd1);
        check("beq_redir", redirect_pc, 32'h200);
        check("beq_ack1", {31'd0, commit_ack}, 32'd0);
        check("beq_we1", {31'd0, rf_we}, 32'd0);
        step();
        commit_valid = 1'b0;
        #1;
        check("beq_cntfl", cnt_flush, 32'd1);
        check("beq_fl2", {31'd0, flush_o}, 32'd0);

        // Correctly predicted taken branch retires without a register write.
        head(OpBeq, 5'd9, 32'h0, 32'h118, 32'h400, 1'b1, 1'b1, 32'h400);
        check("brok_ack", {31'd0, commit_ack}, 32'd1);
        check("brok_we", {31'd0, rf_we}, 32'd0);
        step();

        // BNE taken with wrong target.
        head(OpBne, 5'd0, 32'h0, 32'h11C, 32'h304, 1'b1, 1'b1, 32'h300);
        check("bne_ack", {31'd0, commit_ack}, 32'd0);
        step();
        commit_valid = 1'b0;
        #1;
        check("bne_flush", {31'd0, flush_o}, 32'd1);
        check("bne_redir", redirect_pc, 32'h304);
        step();

        // BLT predicted taken but not taken at the top of memory: PC+4 wraps.
        head(OpBlt, 5'd0, 32'h0, 32'hFFFFFFFC, 32'h500, 1'b1, 1'b0, 32'h500);
        step();
        check("blt_flush", {31'd0, flush_o}, 32'd1);
        check("blt_redir", redirect_pc, 32'h0);
        step();
        commit_valid = 1'b0;
        #1;
        check("blt_cntfl", cnt_flush, 32'd3);
        check("cnt_ret6", cnt_retired, 32'd6);

        // Reset in the middle of a store wait.
        head(OpSw, 5'd0, 32'hCAFE, 32'h120, 32'h3000, 1'b0, 1'b0, 32'h0);
        step();
        check("rsw_req", {31'd0, mem_wr_req}, 32'd1);
        rst = 1'b0;
        mem_wr_done = 1'b1;
        #1;
        check("rsw_req_rst", {31'd0, mem_wr_req}, 32'd0);
        check("rsw_ack_rst", {31'd0, commit_ack}, 32'd0);
        step();
        rst = 1'b1;
        mem_wr_done = 1'b0;
        commit_valid = 1'b0;
        #1;
        check("rsw_req_after", {31'd0, mem_wr_req}, 32'd0);
        check("rsw_ack_after", {31'd0, commit_ack}, 32'd0);
        check("rsw_cnt_ret", cnt_retired, 32'd0);
        check("rsw_cnt_fl", cnt_flush, 32'd0);
        check("rsw_addr", mem_wr_addr, 32'd0);
        // Back in IDLE: a plain head retires immediately.
        head(OpAdd, 5'd1, 32'h7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rsw_idle_ack", {31'd0, commit_ack}, 32'd1);
        step();
        commit_valid = 1'b0;
        #1;
        check("rsw_idle_cnt", cnt_retired, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
